pipe_adder: RTL
===============

PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits.
REQ-002 SHALL have parameter CHUNK, default 4, bits added per pipeline stage; WIDTH SHALL be a positive multiple of CHUNK; STAGES = WIDTH/CHUNK.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 in_valid  input  1  operand set presented.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 a  input  WIDTH  operand A, unsigned.
REQ-008 b  input  WIDTH  operand B, unsigned.
REQ-009 sub  input  1  0 = A+B, 1 = A-B; sampled with the operands.
REQ-010 out_valid  output  1  res holds a valid result.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 res  output  WIDTH+1  result; res[WIDTH] = carry out (add) or NOT borrow (sub).

Function
REQ-013 Transfer in SHALL occur when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-014 Subtraction SHALL be A + ~B + 1 (carry-in 1 into chunk 0); addition SHALL use carry-in 0.
REQ-015 Stage k (k = 1..STAGES) SHALL add chunk k-1 of A and B plus the carry registered by stage k-1; lower result chunks and the remaining upper operand chunks SHALL be delay-registered so that all chunks of one transfer leave together.
REQ-016 Latency SHALL be exactly STAGES cycles from input transfer to out_valid, absent stalls.
REQ-017 Stall = out_valid && !out_ready; during a stall every pipeline register, including valid bits, SHALL hold.
REQ-018 in_ready SHALL equal !stall (combinational); a full pipeline with out_ready=1 SHALL sustain one transfer per cycle.
REQ-019 Bubbles (in_valid=0) SHALL propagate as valid=0 slots; they SHALL NOT be collapsed.
REQ-020 res and out_valid SHALL be register outputs; res SHALL hold its value while out_valid && !out_ready.
REQ-021 Arithmetic SHALL wrap modulo 2^WIDTH in res[WIDTH-1:0]; no saturation.
REQ-022 Operand/sub values with in_valid=0 SHALL have no effect on any output.

Reset
REQ-023 While rst_n=0 at a clock edge, all valid bits, out_valid, res and internal carry/data registers SHALL clear to 0.
REQ-024 Reset mid-operation SHALL discard all in-flight results; none SHALL emerge afterwards.
REQ-025 in_ready SHALL be 1 in the first cycle after reset release.

Configuration
REQ-026 Macro PIPE_ADDER_OVF_EN: when defined, an output ovf (1 bit) SHALL exist, registered alongside res, set to signed two's-complement overflow of the operation (add: sign(A)=sign(B)!=sign(sum); sub: sign(A)!=sign(B) and sign(diff)!=sign(A)), 0 at reset.
REQ-027 When PIPE_ADDER_OVF_EN is undefined, port ovf and its logic SHALL be absent; all other behaviour identical.

Verification (WIDTH=8, CHUNK=4 unless stated)
REQ-028 Reset then a=100,b=77,sub=0 one cycle -> after 2 cycles out_valid=1, res=9'b0_1011_0001 (177); ovf=1 if OVF enabled.
REQ-029 Back-to-back a=255,b=1 then a=70,b=35 then sub=1 a=35,b=70, out_ready=1 -> consecutive results 9'h100, 9'h069 (105), 9'h0DD (borrow, res[8]=0).
REQ-030 Pipeline full, out_ready=0 for 3 cycles -> in_ready=0, res and out_valid frozen; out_ready=1 -> results emerge in order, none lost or duplicated.
REQ-031 Inject a=70,b=35, assert rst_n=0 one cycle after acceptance -> out_valid stays 0 for the following 4 cycles; in_ready=1 after release.
REQ-032 WIDTH=16, CHUNK=4: a=16'hFFFF,b=16'h0001 -> after 4 cycles res=17'h10000; sub=1 a=16'h8000,b=16'h0001 -> res=17'h17FFF, ovf=1.
REQ-033 Random 10,000 transfers with random in_valid/out_ready, WIDTH in {8,12,16} -> every res matches reference A±B in order.

Source files
------------

// File: rtl/pipe_adder.sv
// Chunked ripple-pipelined adder/subtractor with valid/ready flow control.
// Optional signed-overflow output is enabled by defining PIPE_ADDER_OVF_EN.
module pipe_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   res
`ifdef PIPE_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int STAGES = WIDTH / CHUNK;

  // Stage k (index k) registers: operands still to be summed, partial sum, carry, valid.
  logic [WIDTH-1:0] a_p   [STAGES];
  logic [WIDTH-1:0] b_p   [STAGES];
  logic [WIDTH-1:0] s_p   [STAGES];
  logic             c_p   [STAGES];
  logic             vld_p [STAGES];

  logic [WIDTH-1:0] a_in  [STAGES];
  logic [WIDTH-1:0] b_in  [STAGES];
  logic [WIDTH-1:0] s_in  [STAGES];
  logic             c_in  [STAGES];
  logic             v_in  [STAGES];
  logic [WIDTH-1:0] s_nxt [STAGES];
  logic [CHUNK:0]   sum_c [STAGES];

  logic stall;

  function automatic logic [CHUNK:0] chunk_add(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic cin, input int k);
    logic [CHUNK-1:0] xc;
    logic [CHUNK-1:0] yc;
    xc = x[k*CHUNK +: CHUNK];
    yc = y[k*CHUNK +: CHUNK];
    return {1'b0, xc} + {1'b0, yc} + {{CHUNK{1'b0}}, cin};
  endfunction

  assign stall    = vld_p[STAGES-1] && !out_ready;
  assign in_ready = !stall;

  // Subtraction enters as A + ~B with the carry-in of chunk 0 set.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      if (k == 0) begin
        a_in[k] = a;
        b_in[k] = sub ? ~b : b;
        s_in[k] = '0;
        c_in[k] = sub;
        v_in[k] = in_valid;
      end else begin
        a_in[k] = a_p[k-1];
        b_in[k] = b_p[k-1];
        s_in[k] = s_p[k-1];
        c_in[k] = c_p[k-1];
        v_in[k] = vld_p[k-1];
      end
      sum_c[k] = chunk_add(a_in[k], b_in[k], c_in[k], k);
      s_nxt[k] = s_in[k];
      s_nxt[k][k*CHUNK +: CHUNK] = sum_c[k][CHUNK-1:0];
    end
  end

  // ---- stage registers: all stages advance together unless the output stalls
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_p[k] <= 1'b0;
        c_p[k]   <= 1'b0;
        a_p[k]   <= '0;
        b_p[k]   <= '0;
        s_p[k]   <= '0;
      end
    end else if (!stall) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_p[k] <= v_in[k];
        // Data only moves with a valid slot so bubbles leave res untouched.
        if (v_in[k]) begin
          a_p[k] <= a_in[k];
          b_p[k] <= b_in[k];
          s_p[k] <= s_nxt[k];
          c_p[k] <= sum_c[k][CHUNK];
        end
      end
    end
  end

  assign out_valid = vld_p[STAGES-1];
  assign res       = {c_p[STAGES-1], s_p[STAGES-1]};

`ifdef PIPE_ADDER_OVF_EN
  logic ovf_p;

  // ---- overflow flag, registered with the final stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_p <= 1'b0;
    end else if (!stall && v_in[STAGES-1]) begin
      ovf_p <= (a_in[STAGES-1][WIDTH-1] == b_in[STAGES-1][WIDTH-1]) &&
               (s_nxt[STAGES-1][WIDTH-1] != a_in[STAGES-1][WIDTH-1]);
    end
  end

  assign ovf = ovf_p;
`endif

endmodule
